// File: rtl/cla_pkg.sv
// Shared constants, width helpers and types for the pipelined CLA adder.
package cla_pkg;

   // Bits handled by one cla4 lookahead group.
   localparam int unsigned CLA_GROUP = 4;

   // Bits computed by each pipeline stage.
   function automatic int unsigned slice_width(input int unsigned width,
                                               input int unsigned stages);
      return width / stages;
   endfunction

   // Number of 4-bit lookahead groups inside one stage slice.
   function automatic int unsigned group_count(input int unsigned width,
                                               input int unsigned stages);
      return width / (stages * CLA_GROUP);
   endfunction

   // Group propagate / generate pair from a cla4.
   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

endpackage

// File: rtl/cla_pipe_if.sv
// Handshake and operand/result bus of cla_pipe.
// The ovf signal exists only when CLA_PIPE_OVF_EN is defined.
interface cla_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
`ifdef CLA_PIPE_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, s, co
`ifdef CLA_PIPE_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, s, co
`ifdef CLA_PIPE_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate. Purely combinational.
module cla4
   import cla_pkg::*;
(
   input  logic [CLA_GROUP-1:0] i_a,
   input  logic [CLA_GROUP-1:0] i_b,
   input  logic                 i_ci,
   output logic [CLA_GROUP-1:0] o_s,
   output pg_t                  o_pg
);
   logic [CLA_GROUP-1:0] w_p;
   logic [CLA_GROUP-1:0] w_g;
   logic [CLA_GROUP-1:0] w_c;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Bit carries expanded in two-level form so no ripple inside the group.
   assign w_c[0] = i_ci;
   assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_ci);

   assign o_s    = w_p ^ w_c;
   assign o_pg.p = &w_p;
   assign o_pg.g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage k adds bits [k*SLICE +: SLICE]; unconsumed operand bits and finished sum bits
// travel down the pipe beside the slice carry. Latency = STAGES cycles, one beat per cycle.
// Define CLA_PIPE_OVF_EN to add the signed-overflow output.
module cla_pipe
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input logic        clk,
   input logic        reset_n,
   cla_pipe_if.slave  bus
);
   localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
   localparam int unsigned NGRP  = group_count(WIDTH, STAGES);

   if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % (CLA_GROUP * STAGES)) != 0)) begin : g_cfg_err
      $error("cla_pipe: WIDTH must be a multiple of 4*STAGES and STAGES must be 1..8");
   end

   logic [WIDTH-1:0] w_bx;     // B after optional inversion for subtract
   logic             w_c0;     // carry into bit 0
   logic [STAGES-1:0] w_v;
   logic [STAGES:0]   w_adv;

   // Subtract is a + ~b + ~ci, so a borrow-in becomes a cleared carry-in.
   assign w_bx = bus.sub ? ~bus.b : bus.b;
   assign w_c0 = bus.sub ^ bus.ci;

   // Ready chain: a stage advances if it is empty or its successor advances.
   always_comb begin
      w_adv         = '0;
      w_adv[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_adv[k] = !w_v[k] || w_adv[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned LO  = k * SLICE;
      localparam int unsigned HI  = LO + SLICE;
      localparam int unsigned REM = WIDTH - HI;

      logic [SLICE-1:0] w_sa;
      logic [SLICE-1:0] w_sb;
      logic [SLICE-1:0] w_ssum;
      logic             w_cin;
      logic             w_vin;
      logic [HI-1:0]    w_sum_d;
      pg_t [NGRP-1:0]   w_pg;
      logic [NGRP:0]    w_gc;

      logic             r_v;
      logic             r_c;
      logic [HI-1:0]    r_sum;

      if (k == 0) begin : g_src
         assign w_sa    = bus.a[SLICE-1:0];
         assign w_sb    = w_bx[SLICE-1:0];
         assign w_cin   = w_c0;
         assign w_vin   = bus.in_valid;
         assign w_sum_d = w_ssum;
      end else begin : g_src
         assign w_sa    = g_stg[k-1].g_ops.r_a[SLICE-1:0];
         assign w_sb    = g_stg[k-1].g_ops.r_b[SLICE-1:0];
         assign w_cin   = g_stg[k-1].r_c;
         assign w_vin   = g_stg[k-1].r_v;
         assign w_sum_d = {w_ssum, g_stg[k-1].r_sum};
      end

      for (genvar j = 0; j < NGRP; j++) begin : g_grp
         cla4 u_cla4 (
            .i_a  (w_sa[j*CLA_GROUP +: CLA_GROUP]),
            .i_b  (w_sb[j*CLA_GROUP +: CLA_GROUP]),
            .i_ci (w_gc[j]),
            .o_s  (w_ssum[j*CLA_GROUP +: CLA_GROUP]),
            .o_pg (w_pg[j])
         );
      end

      // Slice-level lookahead: group carries from group P/G and the stage carry-in.
      always_comb begin
         logic c;
         w_gc = '0;
         c    = w_cin;
         for (int j = 0; j < NGRP; j++) begin
            w_gc[j] = c;
            c       = w_pg[j].g | (w_pg[j].p & c);
         end
         w_gc[NGRP] = c;
      end

      // Stage valid, slice carry-out and accumulated sum bits.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_sum <= '0;
         end else if (w_adv[k]) begin
            r_v <= w_vin;
            if (w_vin) begin
               r_c   <= w_gc[NGRP];
               r_sum <= w_sum_d;
            end
         end
      end

      // Operand bits not yet consumed; the last stage has none left.
      if (REM > 0) begin : g_ops
         logic [REM-1:0] w_ua;
         logic [REM-1:0] w_ub;
         logic [REM-1:0] r_a;
         logic [REM-1:0] r_b;

         if (k == 0) begin : g_usrc
            assign w_ua = bus.a[WIDTH-1:HI];
            assign w_ub = w_bx[WIDTH-1:HI];
         end else begin : g_usrc
            assign w_ua = g_stg[k-1].g_ops.r_a[WIDTH-LO-1:SLICE];
            assign w_ub = g_stg[k-1].g_ops.r_b[WIDTH-LO-1:SLICE];
         end

         // Delay line for the upper operand bits.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv[k] && w_vin) begin
               r_a <= w_ua;
               r_b <= w_ub;
            end
         end
      end

`ifdef CLA_PIPE_OVF_EN
      // The operand MSBs reach the last stage through the operand delay line.
      if (k == STAGES - 1) begin : g_ovf
         logic r_ovf;

         // Signed overflow: same-sign operands giving a result of the other sign.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_ovf <= 1'b0;
            end else if (w_adv[k] && w_vin) begin
               r_ovf <= (w_sa[SLICE-1] == w_sb[SLICE-1]) && (w_ssum[SLICE-1] != w_sa[SLICE-1]);
            end
         end
      end
`endif

      assign w_v[k] = r_v;
   end

   assign bus.in_ready  = w_adv[0];
   assign bus.out_valid = w_v[STAGES-1];
   assign bus.s         = g_stg[STAGES-1].r_sum;
   assign bus.co        = g_stg[STAGES-1].r_c;
`ifdef CLA_PIPE_OVF_EN
   assign bus.ovf       = g_stg[STAGES-1].g_ovf.r_ovf;
`endif
endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. It splits a WIDTH-bit add into STAGES register-separated slices and ripples the slice carry through pipeline registers. It sustains one operation per clock and exposes a carry/borrow out. It replaces the single-cycle 32-bit CLA in the datapath wherever timing closure at the target clock needs a registered adder.

## Interface
- WIDTH, 32: operand width; must be a multiple of 4*STAGES.
- STAGES, 4: pipeline depth; equals latency in cycles; 1..8.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous reset, active-low; the only reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: s = a + b + ci; 1: s = a - b - ci.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- co  out  1  add: carry out; sub: 1 = no borrow, 0 = borrow.
- ovf  out  1  signed overflow; only present with CLA_PIPE_OVF_EN.

## Operation
- Effective add: B' = sub ? ~b : b; c0 = sub ? ~ci : ci; result = a + B' + c0 over WIDTH+1 bits. co is bit WIDTH of that result.
- SLICE = WIDTH/STAGES. Stage k (0-based) computes bits [k*SLICE +: SLICE] with 4-bit CLA groups and a group lookahead across the slice. Its carry-in is the registered carry from stage k-1, or c0 for stage 0.
- Operand bits above the current slice travel down the pipe in delay registers. Finished sum bits travel alongside them. Upper bits are dropped as they are consumed, so register area shrinks.
- Each stage holds a valid bit vk. Stage k loads when adv_k = !vk || adv_{k+1}. adv_STAGES = out_ready.
- in_ready = adv_0. A beat transfers when in_valid && in_ready.
- Bubbles collapse: an empty stage always loads from upstream, even when downstream is stalled.
- out_valid = v_{STAGES-1}. s, co and ovf come from the last-stage registers and hold stable while out_valid && !out_ready.
- The ready path is combinational from out_ready through all stages to in_ready. This is accepted for STAGES ≤ 8.

## Timing
- Reset (reset_n low, asynchronous): every vk = 0, out_valid = 0, s = 0, co = 0, ovf = 0. in_ready = 1 immediately after reset deasserts.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES-1, i.e. it is visible during cycle n+STAGES.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: with out_ready = 0 and all stages full, in_ready = 0. No beat is lost or duplicated.
- Simultaneous pop and push when full: both occur in the same cycle.
- Reset mid-operation drops all in-flight beats. The data registers need not be cleared beyond the outputs, but the outputs read 0.
- Wrap-around: 0xFFFFFFFF + 1 gives s = 0, co = 1, with no special casing.

## Configuration
- CLA_PIPE_OVF_EN defined: the ovf port exists. ovf = (a[MSB] == B'[MSB]) && (s[MSB] != a[MSB]). This requires a[MSB] and B'[MSB] to be carried to the last stage.
- Undefined: there is no ovf port and no MSB delay registers. All other behaviour is identical.

## Structure
- Package cla_pkg holds: the CLA_GROUP = 4 constant; localparam helpers for the SLICE and group-count computations; and a typedef for the per-group {p, g} pair.
- Sub-module cla4: a 4-bit CLA with inputs a, b, ci and outputs s, group P, group G. Each stage instantiates SLICE/4 of them plus a slice-level lookahead. The block is purely combinational.
- The top level holds the stage registers, valid chain and delay lines, built with generate loops over STAGES.

## Test plan
- WIDTH=32, STAGES=4, add 38297 + 126625, ci=0 -> s=164922, co=0, out_valid exactly 4 cycles after acceptance.
- Add 0xFFFFFFFF + 1, ci=0 -> s=0, co=1. Add 0 + 0xFFFFFFFF, ci=1 -> s=0, co=1.
- Sub 100 - 100, ci=0 -> s=0, co=1. Sub 0 - 1, ci=0 -> s=0xFFFFFFFF, co=0. Sub 100 - 99, ci=1 -> s=0, co=1.
- Stream 10 back-to-back beats with out_ready toggling in a 1010 pattern -> results come out in order, none lost, s/co held stable during stalls, in_ready drops only when all 4 stages are full.
- Assert reset_n low with 3 beats in flight -> out_valid = 0 and s = 0 asynchronously. The next accepted beat computes correctly.
- With CLA_PIPE_OVF_EN: 0x7FFFFFFF + 1 -> ovf=1. Sub 0x80000000 - 1 -> ovf=1. 5 + 3 -> ovf=0. Repeat with STAGES=1 and STAGES=8.
